// File: rtl/pass_sequencer_pkg.sv
// Shared types and default network dimensions for the training pass sequencer.
package pass_sequencer_pkg;

  // Sequencer states; pass flags are decoded directly from these.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StF0   = 3'd1,
    StF1   = 3'd2,
    StBp   = 3'd3,
    StDone = 3'd4
  } state_e;

  // Default network dimensions.
  localparam int unsigned NInDefault  = 4;
  localparam int unsigned NHidDefault = 4;
  localparam int unsigned NOutDefault = 2;

  // True while the state issues MAC beats.
  function automatic logic is_pass(state_e s);
    return (s == StF0) || (s == StF1) || (s == StBp);
  endfunction

endpackage

// File: rtl/pass_sequencer_rc_counter.sv
// Nested row/column counter: column is the inner loop, row the outer loop.
module rc_counter #(
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] row_max_i,
  input  logic [IDX_W-1:0] col_max_i,
  output logic [IDX_W-1:0] row_o,
  output logic [IDX_W-1:0] col_o,
  output logic             last_col_o,
  output logic             last_all_o
);

  logic [IDX_W-1:0] r_row;
  logic [IDX_W-1:0] r_col;
  logic [IDX_W-1:0] w_row_d;
  logic [IDX_W-1:0] w_col_d;

  assign last_col_o = (r_col == col_max_i);
  assign last_all_o = last_col_o && (r_row == row_max_i);
  assign row_o      = r_row;
  assign col_o      = r_col;

  // Next index: clear wins, otherwise advance column then row, wrapping both at the end.
  always_comb begin
    w_row_d = r_row;
    w_col_d = r_col;
    if (clr_i) begin
      w_row_d = '0;
      w_col_d = '0;
    end else if (step_i) begin
      if (last_all_o) begin
        w_row_d = '0;
        w_col_d = '0;
      end else if (last_col_o) begin
        w_row_d = r_row + IDX_W'(1);
        w_col_d = '0;
      end else begin
        w_col_d = r_col + IDX_W'(1);
      end
    end
  end

  // Index registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_row <= w_row_d;
      r_col <= w_col_d;
    end
  end

endmodule

// File: rtl/pass_sequencer.sv
// Steps the shared MAC datapath through f0, f1 and (optionally) backward passes per sample.
module pass_sequencer
  import pass_sequencer_pkg::*;
#(
  parameter int unsigned N_IN   = NInDefault,
  parameter int unsigned N_HID  = NHidDefault,
  parameter int unsigned N_OUT  = NOutDefault,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned SAMP_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              init_i,
  input  logic              abort_i,
  input  logic              train_i,
  input  logic [SAMP_W-1:0] n_samples_i,
  input  logic              mac_ready_i,
  output logic              mac_valid_o,
  output logic [IDX_W-1:0]  row_o,
  output logic [IDX_W-1:0]  col_o,
  output logic              acc_clr_o,
  output logic              acc_wr_o,
  output logic              f0_pass_o,
  output logic              f1_pass_o,
  output logic              b_pass_o,
  output logic [SAMP_W-1:0] sample_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e            r_state;
  state_e            w_state_d;
  logic              r_train;
  logic              w_train_d;
  logic [SAMP_W-1:0] r_nsamp;
  logic [SAMP_W-1:0] w_nsamp_d;
  logic [SAMP_W-1:0] r_sample;
  logic [SAMP_W-1:0] w_sample_d;

  logic [IDX_W-1:0]  w_row_max;
  logic [IDX_W-1:0]  w_col_max;
  logic              w_step;
  logic              w_clr;
  logic              w_last_col;
  logic              w_last_all;
  logic              w_valid;
  logic              w_xfer;
  logic              w_last_sample;

  // Pass geometry selected by the current state.
  always_comb begin
    w_row_max = '0;
    w_col_max = '0;
    unique case (r_state)
      StF0: begin
        w_row_max = IDX_W'(N_HID - 1);
        w_col_max = IDX_W'(N_IN - 1);
      end
      StF1: begin
        w_row_max = IDX_W'(N_OUT - 1);
        w_col_max = IDX_W'(N_HID - 1);
      end
      StBp: begin
        w_row_max = IDX_W'(N_HID - 1);
        w_col_max = IDX_W'(N_OUT - 1);
      end
      default: begin
        w_row_max = '0;
        w_col_max = '0;
      end
    endcase
  end

  rc_counter #(
    .IDX_W(IDX_W)
  ) u_rc_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .step_i     (w_step),
    .clr_i      (w_clr),
    .row_max_i  (w_row_max),
    .col_max_i  (w_col_max),
    .row_o      (row_o),
    .col_o      (col_o),
    .last_col_o (w_last_col),
    .last_all_o (w_last_all)
  );

  assign w_valid       = en_i && is_pass(r_state);
  assign w_xfer        = w_valid && mac_ready_i;
  assign w_last_sample = (r_sample == (r_nsamp - SAMP_W'(1)));

  // Next-state logic; en_i low leaves every register untouched.
  always_comb begin
    w_state_d  = r_state;
    w_train_d  = r_train;
    w_nsamp_d  = r_nsamp;
    w_sample_d = r_sample;
    w_step     = 1'b0;
    w_clr      = 1'b0;
    if (en_i) begin
      if (abort_i && (r_state != StIdle)) begin
        w_state_d  = StIdle;
        w_sample_d = '0;
        w_clr      = 1'b1;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (init_i) begin
              w_train_d  = train_i;
              w_nsamp_d  = n_samples_i;
              w_sample_d = '0;
              w_clr      = 1'b1;
              w_state_d  = (n_samples_i == '0) ? StDone : StF0;
            end
          end
          StF0, StF1, StBp: begin
            if (w_xfer) begin
              w_step = 1'b1;
              if (w_last_all) begin
                // Sample ends after f1 in inference, after the backward pass in training.
                if ((r_state == StF0) || ((r_state == StF1) && r_train)) begin
                  w_state_d = (r_state == StF0) ? StF1 : StBp;
                end else if (w_last_sample) begin
                  w_state_d = StDone;
                end else begin
                  w_sample_d = r_sample + SAMP_W'(1);
                  w_state_d  = StF0;
                end
              end
            end
          end
          StDone: begin
            w_state_d = StIdle;
          end
          default: begin
            w_state_d = StIdle;
          end
        endcase
      end
    end
  end

  // State and latched run configuration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_train  <= 1'b0;
      r_nsamp  <= '0;
      r_sample <= '0;
    end else begin
      r_state  <= w_state_d;
      r_train  <= w_train_d;
      r_nsamp  <= w_nsamp_d;
      r_sample <= w_sample_d;
    end
  end

  assign mac_valid_o = w_valid;
  assign acc_clr_o   = w_valid && (col_o == '0);
  assign acc_wr_o    = w_xfer && w_last_col;
  assign f0_pass_o   = (r_state == StF0);
  assign f1_pass_o   = (r_state == StF1);
  assign b_pass_o    = (r_state == StBp);
  assign sample_o    = r_sample;
  assign busy_o      = (r_state != StIdle);
  // An abort in DONE suppresses the completion pulse.
  assign done_o      = en_i && !abort_i && (r_state == StDone);

endmodule

// File: tb/tb_pass_sequencer.sv
// Directed bench for pass_sequencer with hand-computed cycle expectations.
module tb_pass_sequencer;

  localparam int IDX_W  = 3;
  localparam int SAMP_W = 4;
  localparam int MAXC   = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              init;
  logic              abort;
  logic              train;
  logic [SAMP_W-1:0] n_samples;
  logic              ready;
  logic              valid;
  logic [IDX_W-1:0]  row;
  logic [IDX_W-1:0]  col;
  logic              acc_clr;
  logic              acc_wr;
  logic              f0;
  logic              f1;
  logic              bp;
  logic [SAMP_W-1:0] sample;
  logic              busy;
  logic              done;

  int n_vec = 0;
  int n_bad = 0;

  // Per-cycle recordings of the last run, indexed by cycle number.
  logic [IDX_W-1:0]  a_row    [0:MAXC];
  logic [IDX_W-1:0]  a_col    [0:MAXC];
  logic              a_valid  [0:MAXC];
  logic              a_clr    [0:MAXC];
  logic              a_busy   [0:MAXC];
  logic              a_f1     [0:MAXC];
  logic              a_b      [0:MAXC];
  logic              a_done   [0:MAXC];
  logic [SAMP_W-1:0] a_sample [0:MAXC];
  int f0_first, f0_last, f1_first, f1_last, b_first, b_last;
  int wr_cnt, clr_cnt, valid_cnt, done_cnt, done_cyc, b_cnt, s1_cyc, s2_cyc;

  always #5 clk = ~clk;

  pass_sequencer u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .init_i      (init),
    .abort_i     (abort),
    .train_i     (train),
    .n_samples_i (n_samples),
    .mac_ready_i (ready),
    .mac_valid_o (valid),
    .row_o       (row),
    .col_o       (col),
    .acc_clr_o   (acc_clr),
    .acc_wr_o    (acc_wr),
    .f0_pass_o   (f0),
    .f1_pass_o   (f1),
    .b_pass_o    (bp),
    .sample_o    (sample),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Mode 0 plain, 1 ready low in cycles 5-7, 2 en low in 19-23 then abort in 32,
  // 3 stray init pulse in cycle 10.
  task automatic run(input logic tr, input logic [SAMP_W-1:0] ns, input int ncyc, input int mode);
    f0_first = 0; f0_last = 0; f1_first = 0; f1_last = 0; b_first = 0; b_last = 0;
    wr_cnt = 0; clr_cnt = 0; valid_cnt = 0; done_cnt = 0; done_cyc = 0; b_cnt = 0;
    s1_cyc = 0; s2_cyc = 0;
    train = tr; n_samples = ns; init = 1'b1; en = 1'b1; ready = 1'b1; abort = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      #1;
      init  = (mode == 3) && (c == 10);
      ready = !((mode == 1) && (c >= 5) && (c <= 7));
      en    = !((mode == 2) && (c >= 19) && (c <= 23));
      abort = (mode == 2) && (c == 32);
      #1;
      a_row[c] = row; a_col[c] = col; a_valid[c] = valid; a_clr[c] = acc_clr;
      a_busy[c] = busy; a_f1[c] = f1; a_b[c] = bp; a_done[c] = done; a_sample[c] = sample;
      if (f0) begin if (f0_first == 0) f0_first = c; f0_last = c; end
      if (f1) begin if (f1_first == 0) f1_first = c; f1_last = c; end
      if (bp) begin if (b_first == 0) b_first = c; b_last = c; b_cnt++; end
      if (acc_wr) wr_cnt++;
      if (acc_clr) clr_cnt++;
      if (valid) valid_cnt++;
      if (done) begin done_cnt++; done_cyc = c; end
      if ((sample == 1) && (s1_cyc == 0)) s1_cyc = c;
      if ((sample == 2) && (s2_cyc == 0)) s2_cyc = c;
      @(posedge clk);
    end
    #1;
    init = 1'b0; abort = 1'b0; en = 1'b1; ready = 1'b1;
  endtask

  initial begin
    int hold_ok;
    int frz_bad;
    rst = 1'b1; en = 1'b1; init = 1'b0; abort = 1'b0; train = 1'b0;
    n_samples = '0; ready = 1'b1;
    #2;
    check("reset_busy_valid_done", {busy, valid, done, acc_clr, acc_wr}, 0);
    check("reset_flags", {f0, f1, bp}, 0);
    check("reset_idx", {row, col, sample}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic training run, one sample.
    run(1'b1, 4'd1, 40, 0);
    check("train_f0_first", f0_first, 1);
    check("train_f0_last", f0_last, 16);
    check("train_f1_first", f1_first, 17);
    check("train_f1_last", f1_last, 24);
    check("train_b_first", b_first, 25);
    check("train_b_last", b_last, 32);
    check("train_done_cyc", done_cyc, 33);
    check("train_done_cnt", done_cnt, 1);
    check("train_busy_34", a_busy[34], 0);
    check("train_wr_cnt", wr_cnt, 10);
    check("train_clr_cnt", clr_cnt, 10);
    check("train_c2_idx", {a_row[2], a_col[2]}, {3'd0, 3'd1});
    check("train_c6_idx", {a_row[6], a_col[6]}, {3'd1, 3'd1});

    // Inference, three samples.
    run(1'b0, 4'd3, 80, 0);
    check("inf_b_cnt", b_cnt, 0);
    check("inf_s1_cyc", s1_cyc, 25);
    check("inf_s2_cyc", s2_cyc, 49);
    check("inf_done_cyc", done_cyc, 73);
    check("inf_sample_hold", a_sample[76], 2);
    check("inf_wr_cnt", wr_cnt, 18);

    // Backpressure at f0 row 1 col 0.
    run(1'b1, 4'd1, 45, 1);
    hold_ok = 0;
    for (int c = 5; c <= 8; c++) begin
      if ((a_row[c] == 1) && (a_col[c] == 0) && a_clr[c] && a_valid[c]) hold_ok++;
    end
    check("bp_hold_cycles", hold_ok, 4);
    check("bp_c9_idx", {a_row[9], a_col[9]}, {3'd1, 3'd1});
    check("bp_done_cyc", done_cyc, 36);
    check("bp_wr_cnt", wr_cnt, 10);

    // Freeze in f1, then abort during the backward pass.
    run(1'b1, 4'd1, 40, 2);
    frz_bad = 0;
    for (int c = 19; c <= 23; c++) begin
      if (a_valid[c] || a_done[c] || a_clr[c] || (a_col[c] != 2) || (a_row[c] != 0)) frz_bad++;
    end
    check("frz_bad_cycles", frz_bad, 0);
    check("frz_f1_held", a_f1[21], 1);
    check("frz_resume", {a_valid[24], a_row[24], a_col[24]}, {1'b1, 3'd0, 3'd2});
    check("frz_b_start", b_first, 30);
    check("abort_state", {a_b[32], a_busy[33]}, {1'b1, 1'b0});
    check("abort_sample", a_sample[33], 0);
    check("abort_no_done", done_cnt, 0);

    // Zero samples.
    run(1'b1, 4'd0, 5, 0);
    check("n0_done_cyc", done_cyc, 1);
    check("n0_done_cnt", done_cnt, 1);
    check("n0_busy", {a_busy[1], a_busy[2]}, {1'b1, 1'b0});
    check("n0_valid_cnt", valid_cnt, 0);

    // Stray init while busy.
    run(1'b1, 4'd1, 40, 3);
    check("ign_f0_last", f0_last, 16);
    check("ign_done_cyc", done_cyc, 33);
    check("ign_wr_cnt", wr_cnt, 10);

    // Asynchronous reset mid-f0.
    train = 1'b1; n_samples = 4'd2; init = 1'b1;
    @(posedge clk); #1 init = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_busy", {busy, f0, valid}, 3'b111);
    #2 rst = 1'b1;
    #1;
    check("rst_ctrl", {busy, valid, acc_clr, acc_wr, done}, 0);
    check("rst_flags", {f0, f1, bp}, 0);
    check("rst_idx", {row, col, sample}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {busy, valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
